// File: rtl/dot_pkg.sv
// Shared defaults, width helpers and controller state type for the dot-product streamer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package dot_pkg;

  localparam int DEF_NUM_ELEMENTS  = 8;
  localparam int DEF_ELEMENT_WIDTH = 8;
  localparam int DEF_MAX_CHUNKS    = 256;

  // Width of one chunk's dot product: full product plus growth of the adder tree.
  function automatic int chunk_sum_w(input int num_elements, input int element_width);
    return 2 * element_width + $clog2(num_elements);
  endfunction

  // Accumulator width: sized so MAX_CHUNKS worst-case chunk sums can never wrap.
  function automatic int acc_w(input int num_elements, input int element_width,
                               input int max_chunks);
    return chunk_sum_w(num_elements, element_width) + $clog2(max_chunks);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/dot_lane_tree.sv
// Combinational NUM_ELEMENTS-lane unsigned multiply followed by a pairwise adder tree.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is captured.
module dot_lane_tree
  import dot_pkg::*;
#(
  parameter int NUM_ELEMENTS    = DEF_NUM_ELEMENTS,
  parameter int ELEMENT_WIDTH   = DEF_ELEMENT_WIDTH,
  parameter int CHUNK_SUM_WIDTH = chunk_sum_w(NUM_ELEMENTS, ELEMENT_WIDTH)
) (
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] i_vec_a,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] i_vec_b,
  output logic [CHUNK_SUM_WIDTH-1:0]            o_sum
);

  // The tree is built over the next power of two; missing leaves contribute zero.
  localparam int LEAVES = 1 << $clog2(NUM_ELEMENTS);
  localparam int PW     = 2 * ELEMENT_WIDTH;

  // Heap layout: node k sums nodes 2k and 2k+1, leaves sit at LEAVES..2*LEAVES-1.
  logic [CHUNK_SUM_WIDTH-1:0] w_node [1:2*LEAVES-1];

  genvar g;
  generate
    for (g = 0; g < LEAVES; g++) begin : g_leaf
      if (g < NUM_ELEMENTS) begin : g_mul
        logic [PW-1:0] w_prod;
        assign w_prod = PW'(i_vec_a[g*ELEMENT_WIDTH +: ELEMENT_WIDTH])
                      * PW'(i_vec_b[g*ELEMENT_WIDTH +: ELEMENT_WIDTH]);
        assign w_node[LEAVES+g] = CHUNK_SUM_WIDTH'(w_prod);
      end else begin : g_pad
        assign w_node[LEAVES+g] = '0;
      end
    end
    for (g = 1; g < LEAVES; g++) begin : g_add
      assign w_node[g] = w_node[2*g] + w_node[2*g+1];
    end
  endgenerate

  assign o_sum = w_node[1];

endmodule

// File: rtl/dot_product_stream_ctrl.sv
// Streams chunk pairs through one shared lane tree and accumulates one dot product per command.
// Latency: result valid two edges after the last chunk is accepted.
// Backpressure: cmd_ready only in IDLE, in_ready only in RUN; result held until res_ready.
module dot_product_stream_ctrl
  import dot_pkg::*;
#(
  parameter int NUM_ELEMENTS    = DEF_NUM_ELEMENTS,
  parameter int ELEMENT_WIDTH   = DEF_ELEMENT_WIDTH,
  parameter int MAX_CHUNKS      = DEF_MAX_CHUNKS,
  parameter int CHUNK_SUM_WIDTH = chunk_sum_w(NUM_ELEMENTS, ELEMENT_WIDTH),
  parameter int ACC_WIDTH       = acc_w(NUM_ELEMENTS, ELEMENT_WIDTH, MAX_CHUNKS)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [$clog2(MAX_CHUNKS)-1:0]         cmd_len,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] vec_a,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] vec_b,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [ACC_WIDTH-1:0]                  res_data,
  output logic                                  busy
);

  localparam int CNT_W = $clog2(MAX_CHUNKS);

  ctrl_state_e                r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [CHUNK_SUM_WIDTH-1:0] r_p1;
  logic                       r_p1_vld;
  logic                       r_p1_last;
  logic                       r_acc_done;
  logic [ACC_WIDTH-1:0]       r_acc;
  logic [ACC_WIDTH-1:0]       r_res_data;
  logic                       r_cmd_ready;
  logic                       r_in_ready;
  logic                       r_res_valid;
  logic                       r_busy;

  logic [CHUNK_SUM_WIDTH-1:0] w_chunk_sum;
  logic                       w_beat;
  logic [ACC_WIDTH-1:0]       w_acc_next;

  dot_lane_tree #(
    .NUM_ELEMENTS    (NUM_ELEMENTS),
    .ELEMENT_WIDTH   (ELEMENT_WIDTH),
    .CHUNK_SUM_WIDTH (CHUNK_SUM_WIDTH)
  ) u_lane_tree (
    .i_vec_a (vec_a),
    .i_vec_b (vec_b),
    .o_sum   (w_chunk_sum)
  );

  assign w_beat     = in_valid & r_in_ready;
  assign w_acc_next = r_acc + ACC_WIDTH'(r_p1);

  // Controller: job sequencing, chunk stage, accumulator and registered handshake outputs.
  // The last chunk sum is folded into r_acc one edge after it lands in p1 (r_acc_done marks
  // that), and the following edge publishes r_acc, giving a fixed two-edge result latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_p1        <= '0;
      r_p1_vld    <= 1'b0;
      r_p1_last   <= 1'b0;
      r_acc_done  <= 1'b0;
      r_acc       <= '0;
      r_res_data  <= '0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_p1_vld <= 1'b0;
      if (r_p1_vld) begin
        r_acc <= w_acc_next;
        if (r_p1_last) begin
          r_acc_done <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cnt       <= cmd_len;
            r_acc       <= '0;
            r_acc_done  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_state     <= RUN;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (w_beat) begin
            r_p1      <= w_chunk_sum;
            r_p1_vld  <= 1'b1;
            r_p1_last <= (r_cnt == '0);
            r_cnt     <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (r_acc_done) begin
            r_res_data  <= r_acc;
            r_res_valid <= 1'b1;
            r_acc_done  <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign in_ready  = r_in_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dot_product_stream_ctrl.sv
// Self-checking bench for dot_product_stream_ctrl: table of directed jobs, random jobs against a
// reference dot product, and a mid-job reset sequence.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_dot_product_stream_ctrl;

  localparam int NE   = 8;
  localparam int EW   = 8;
  localparam int ACCW = 27;

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd_len;
  logic                in_valid;
  logic                in_ready;
  logic [NE*EW-1:0]    vec_a;
  logic [NE*EW-1:0]    vec_b;
  logic                res_valid;
  logic                res_ready;
  logic [ACCW-1:0]     res_data;
  logic                busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] g_a[$];
  logic [63:0] g_b[$];

  typedef struct {
    int          nchunks;
    int          pat;
    int          maxgap;
    int          hold;
    bit          poke;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[5];

  dot_product_stream_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Operand patterns: 0 all 0xFF, 1 a=lane+1 b=1, 2 all 2, 3 all 1, otherwise random bytes.
  task automatic fill(input int pat, input int n);
    logic [63:0] va;
    logic [63:0] vb;
    g_a.delete();
    g_b.delete();
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NE; i++) begin
        case (pat)
          0:       begin va[i*8 +: 8] = 8'hFF;     vb[i*8 +: 8] = 8'hFF; end
          1:       begin va[i*8 +: 8] = 8'(i + 1); vb[i*8 +: 8] = 8'd1;  end
          2:       begin va[i*8 +: 8] = 8'd2;      vb[i*8 +: 8] = 8'd2;  end
          3:       begin va[i*8 +: 8] = 8'd1;      vb[i*8 +: 8] = 8'd1;  end
          default: begin va[i*8 +: 8] = 8'($urandom); vb[i*8 +: 8] = 8'($urandom); end
        endcase
      end
      g_a.push_back(va);
      g_b.push_back(vb);
    end
  endtask

  // Reference: plain sum over every chunk and lane of a*b.
  function automatic logic [63:0] model_dot();
    longint      s;
    logic [63:0] va;
    logic [63:0] vb;
    s = 0;
    for (int k = 0; k < g_a.size(); k++) begin
      va = g_a[k];
      vb = g_b[k];
      for (int i = 0; i < NE; i++) begin
        s += longint'(va[i*8 +: 8]) * longint'(vb[i*8 +: 8]);
      end
    end
    return 64'(s);
  endfunction

  // One complete job from the current queues; called at a falling edge with the DUT idle.
  task automatic run_job(input int n, input int maxgap, input int hold, input bit poke,
                         input logic [63:0] exp);
    int gap;
    int w;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = 8'(n - 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_cmd", 64'(busy), 64'd1);
    for (int k = 0; k < n; k++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      vec_a    = g_a[k];
      vec_b    = g_b[k];
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        return;
      end
      if (k == 0 || k == n - 1) chk("busy_run", 64'(busy), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("in_ready_drop", 64'(in_ready), 64'd0);
    chk("res_valid_t0", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("res_valid_t1", 64'(res_valid), 64'd0);
    chk("busy_drain", 64'(busy), 64'd1);
    @(negedge clk);
    chk("res_valid_t2", 64'(res_valid), 64'd1);
    chk("res_data", 64'(res_data), exp);
    for (int h = 0; h < hold; h++) begin
      in_valid  = poke;
      vec_a     = {$urandom, $urandom};
      vec_b     = {$urandom, $urandom};
      cmd_valid = poke;
      cmd_len   = 8'($urandom);
      @(negedge clk);
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_data", 64'(res_data), exp);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    in_valid  = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_clear", 64'(res_valid), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("res_data_kept", 64'(res_data), exp);
  endtask

  initial begin
    tbl[0] = '{nchunks: 1,   pat: 0, maxgap: 0, hold: 0, poke: 1'b0, exp: 64'd520200};
    tbl[1] = '{nchunks: 4,   pat: 1, maxgap: 0, hold: 1, poke: 1'b0, exp: 64'd144};
    tbl[2] = '{nchunks: 3,   pat: 2, maxgap: 3, hold: 0, poke: 1'b0, exp: 64'd96};
    tbl[3] = '{nchunks: 2,   pat: 3, maxgap: 0, hold: 5, poke: 1'b1, exp: 64'd16};
    tbl[4] = '{nchunks: 256, pat: 0, maxgap: 0, hold: 0, poke: 1'b0, exp: 64'd133171200};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    vec_a     = '0;
    vec_b     = '0;
    res_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Chunks offered while idle must be ignored.
    in_valid = 1'b1;
    vec_a    = {8{8'hFF}};
    vec_b    = {8{8'hFF}};
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_in_ignored_busy", 64'(busy), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].pat, tbl[t].nchunks);
      run_job(tbl[t].nchunks, tbl[t].maxgap, tbl[t].hold, tbl[t].poke, tbl[t].exp);
      @(negedge clk);
      chk("bubble_busy", 64'(busy), 64'd0);
    end

    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 6));
      fill(4, n);
      run_job(n, 2, int'($urandom_range(0, 2)), 1'b1, model_dot());
    end

    // Reset in the middle of a 4-chunk job, then a fresh 1-chunk job.
    fill(3, 4);
    cmd_valid = 1'b1;
    cmd_len   = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      vec_a    = g_a[k];
      vec_b    = g_b[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_res_data", 64'(res_data), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    fill(3, 1);
    run_job(1, 0, 0, 1'b0, 64'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
